pcie_rx: RTL and testbench

- Receive-side TLP parser between the PCIe core's 64-bit AXI RX stream and the fabric.
- Decodes host single-DW memory writes into a register-write strobe.
- Decodes host single-DW memory reads into a register-read request, including the completion DW2 needed by the completion generator.
- Realigns and endian-swaps CplD payloads for the block's own 512-byte read requests into tagged 64-bit words.

---
 rtl/pcie_pkg.sv | 36 +++
 rtl/pcie_rx.sv | 253 +++++++++++++++++++++++++
 tb/tb_pcie_rx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_pkg.sv
// Shared PCIe TLP definitions: fmt/type codes, header field positions, DW byte swap.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package pcie_pkg;

   // DW0[31:24] fmt/type codes handled by the receive path
   localparam logic [7:0] MRD32 = 8'h00;
   localparam logic [7:0] MRD64 = 8'h20;
   localparam logic [7:0] MWR32 = 8'h40;
   localparam logic [7:0] MWR64 = 8'h60;
   localparam logic [7:0] CPLD  = 8'h4A;

   // Header field positions within their DW
   localparam int TYPE_HI  = 31;   // DW0 fmt/type
   localparam int TYPE_LO  = 24;
   localparam int EP_BIT   = 14;   // DW0 poisoned
   localparam int LEN_HI   = 9;    // DW0 length in DW
   localparam int LEN_LO   = 0;
   localparam int STAT_HI  = 15;   // completion DW1 status
   localparam int STAT_LO  = 13;
   localparam int BC_LO    = 0;    // completion DW1 byte count (low 10 bits used)
   localparam int TAG_HI   = 15;   // request DW1 / completion DW2 tag
   localparam int TAG_LO   = 8;
   localparam int LADDR_HI = 6;    // lower address bits
   localparam int LADDR_LO = 0;

   // Reverse byte order of one DW (TLP big-endian payload <-> little-endian fabric)
   function automatic logic [31:0] es(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   function automatic logic is_known(input logic [7:0] t);
      return (t == MRD32) || (t == MRD64) || (t == MWR32) || (t == MWR64) || (t == CPLD);
   endfunction

endpackage

// File: rtl/pcie_rx.sv
// pcie_rx: parses the 64-bit AXI RX TLP stream into register write/read strobes and
//   realigned, byte-swapped completion qwords for the block's own 512-byte reads.
// Latency: every output is registered, one clock after the beat that completes it.
// Backpressure: none; rx_tready is 0 only while reset is asserted.
// Ports: clock/reset (async active-high); rx_t* stream in; wr_* write strobe,
//   rd_* read request (+ completion DW2), cpl_* completion data with tag and qword index.
// Option: define PCIE_RX_CPL_STATUS_EN to check completion status/EP, drop failing
//   completions and pulse cpl_error; without it status and EP are ignored.
module pcie_rx
   import pcie_pkg::*;
#(
   parameter int ADDR_BITS = 10
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [63:0]          rx_tdata,
   input  logic                 rx_tvalid,
   input  logic                 rx_tlast,
   output logic                 rx_tready,
   output logic                 wr_valid,
   output logic [ADDR_BITS-1:0] wr_addr,
   output logic [31:0]          wr_data,
   output logic                 rd_valid,
   output logic [ADDR_BITS-1:0] rd_addr,
   output logic [31:0]          rd_dw2,
   output logic                 cpl_valid,
   output logic [63:0]          cpl_data,
   output logic [7:0]           cpl_tag,
`ifdef PCIE_RX_CPL_STATUS_EN
   output logic                 cpl_error,
`endif
   output logic [5:0]           cpl_index
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_HDR     = 3'd1;
   localparam logic [2:0] S_DATA4   = 3'd2;
   localparam logic [2:0] S_CDATA   = 3'd3;
   localparam logic [2:0] S_DISCARD = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [7:0]           type_q, type_d;
   logic [9:0]           len_q, len_d;
   logic [31:0]          dw1_q, dw1_d;
   logic [31:0]          held_q, held_d;      // payload DW carried into the next qword
   logic [5:0]           idx_q, idx_d;        // index of the next completion qword
   logic [ADDR_BITS-1:0] addr64_q, addr64_d;  // MWr64 address waiting for its payload beat

   logic                 wr_valid_q, wr_valid_d;
   logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]          wr_data_q, wr_data_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
   logic [31:0]          rd_dw2_q, rd_dw2_d;
   logic                 cpl_valid_q, cpl_valid_d;
   logic [63:0]          cpl_data_q, cpl_data_d;
   logic [7:0]           cpl_tag_q, cpl_tag_d;
   logic [5:0]           cpl_index_q, cpl_index_d;

`ifdef PCIE_RX_CPL_STATUS_EN
   logic                 ep_q, ep_d;
   logic                 err_q, err_d;
`endif

   // Remaining byte count tells where in the 512-byte request this completion starts;
   // only bits [8:3] form the qword index.
   logic [9:0] cpl_start;
   logic       unused_cpl_start;
   assign cpl_start        = 10'h200 - dw1_q[BC_LO+9:BC_LO];
   assign unused_cpl_start = ^{cpl_start[9], cpl_start[2:0]};

   always_comb begin
      state_d     = state_q;
      type_d      = type_q;
      len_d       = len_q;
      dw1_d       = dw1_q;
      held_d      = held_q;
      idx_d       = idx_q;
      addr64_d    = addr64_q;
      wr_valid_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      rd_valid_d  = 1'b0;
      rd_addr_d   = rd_addr_q;
      rd_dw2_d    = rd_dw2_q;
      cpl_valid_d = 1'b0;
      cpl_data_d  = cpl_data_q;
      cpl_tag_d   = cpl_tag_q;
      cpl_index_d = cpl_index_q;
`ifdef PCIE_RX_CPL_STATUS_EN
      ep_d        = ep_q;
      err_d       = 1'b0;
`endif

      if (rx_tvalid) begin
         case (state_q)
            S_IDLE: begin
               type_d = rx_tdata[TYPE_HI:TYPE_LO];
               len_d  = rx_tdata[LEN_HI:LEN_LO];
               dw1_d  = rx_tdata[63:32];
`ifdef PCIE_RX_CPL_STATUS_EN
               ep_d   = rx_tdata[EP_BIT];
`endif
               if (rx_tlast)
                  state_d = S_IDLE;
               else if (is_known(rx_tdata[TYPE_HI:TYPE_LO]))
                  state_d = S_HDR;
               else
                  state_d = S_DISCARD;
            end

            S_HDR: begin
               // Anything that does not continue below drops the rest of the TLP.
               state_d = rx_tlast ? S_IDLE : S_DISCARD;
               case (type_q)
                  MWR32: begin
                     if (len_q == 10'd1) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = rx_tdata[ADDR_BITS+1:2];
                        wr_data_d  = es(rx_tdata[63:32]);
                     end
                  end
                  MRD32: begin
                     if (len_q == 10'd1) begin
                        rd_valid_d = 1'b1;
                        rd_addr_d  = rx_tdata[ADDR_BITS+1:2];
                        rd_dw2_d   = {dw1_q[31:8], 1'b0, rx_tdata[LADDR_HI:LADDR_LO]};
                     end
                  end
                  MRD64: begin
                     if (len_q == 10'd1) begin
                        rd_valid_d = 1'b1;
                        rd_addr_d  = rx_tdata[32+ADDR_BITS+1:34];
                        rd_dw2_d   = {dw1_q[31:8], 1'b0, rx_tdata[32+LADDR_HI:32+LADDR_LO]};
                     end
                  end
                  MWR64: begin
                     if (len_q == 10'd1 && !rx_tlast) begin
                        addr64_d = rx_tdata[32+ADDR_BITS+1:34];
                        state_d  = S_DATA4;
                     end
                  end
                  CPLD: begin
                     cpl_tag_d = rx_tdata[TAG_HI:TAG_LO];
                     idx_d     = cpl_start[8:3];
                     held_d    = rx_tdata[63:32];
`ifdef PCIE_RX_CPL_STATUS_EN
                     if (ep_q || (dw1_q[STAT_HI:STAT_LO] != 3'd0))
                        err_d = 1'b1;
                     else if (!rx_tlast)
                        state_d = S_CDATA;
`else
                     if (!rx_tlast)
                        state_d = S_CDATA;
`endif
                  end
                  default: ;
               endcase
            end

            S_DATA4: begin
               wr_valid_d = 1'b1;
               wr_addr_d  = addr64_q;
               wr_data_d  = es(rx_tdata[31:0]);
               state_d    = rx_tlast ? S_IDLE : S_DISCARD;
            end

            S_CDATA: begin
               // Header leaves payload one DW out of qword alignment; pair held DW
               // with this beat's lower DW.
               cpl_valid_d = 1'b1;
               cpl_data_d  = {es(rx_tdata[31:0]), es(held_q)};
               cpl_index_d = idx_q;
               idx_d       = idx_q + 6'd1;
               held_d      = rx_tdata[63:32];
               if (rx_tlast)
                  state_d = S_IDLE;
            end

            S_DISCARD: begin
               if (rx_tlast)
                  state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         type_q      <= 8'd0;
         len_q       <= 10'd0;
         dw1_q       <= 32'd0;
         held_q      <= 32'd0;
         idx_q       <= 6'd0;
         addr64_q    <= '0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 32'd0;
         rd_valid_q  <= 1'b0;
         rd_addr_q   <= '0;
         rd_dw2_q    <= 32'd0;
         cpl_valid_q <= 1'b0;
         cpl_data_q  <= 64'd0;
         cpl_tag_q   <= 8'd0;
         cpl_index_q <= 6'd0;
`ifdef PCIE_RX_CPL_STATUS_EN
         ep_q        <= 1'b0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         len_q       <= len_d;
         dw1_q       <= dw1_d;
         held_q      <= held_d;
         idx_q       <= idx_d;
         addr64_q    <= addr64_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_valid_q  <= rd_valid_d;
         rd_addr_q   <= rd_addr_d;
         rd_dw2_q    <= rd_dw2_d;
         cpl_valid_q <= cpl_valid_d;
         cpl_data_q  <= cpl_data_d;
         cpl_tag_q   <= cpl_tag_d;
         cpl_index_q <= cpl_index_d;
`ifdef PCIE_RX_CPL_STATUS_EN
         ep_q        <= ep_d;
         err_q       <= err_d;
`endif
      end
   end

   assign rx_tready = ~reset;
   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign rd_valid  = rd_valid_q;
   assign rd_addr   = rd_addr_q;
   assign rd_dw2    = rd_dw2_q;
   assign cpl_valid = cpl_valid_q;
   assign cpl_data  = cpl_data_q;
   assign cpl_tag   = cpl_tag_q;
   assign cpl_index = cpl_index_q;
`ifdef PCIE_RX_CPL_STATUS_EN
   assign cpl_error = err_q;
`endif

endmodule

// File: tb/tb_pcie_rx.sv
// Directed bench for pcie_rx: register writes/reads, completion realignment,
// discard paths, tvalid gaps and reset in the middle of a completion.
module tb_pcie_rx;

   logic        clock;
   logic        reset;
   logic [63:0] rx_tdata;
   logic        rx_tvalid;
   logic        rx_tlast;
   logic        rx_tready;
   logic        wr_valid;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rd_valid;
   logic [9:0]  rd_addr;
   logic [31:0] rd_dw2;
   logic        cpl_valid;
   logic [63:0] cpl_data;
   logic [7:0]  cpl_tag;
   logic [5:0]  cpl_index;
`ifdef PCIE_RX_CPL_STATUS_EN
   logic        cpl_error;
`endif

   int checks = 0;
   int errors = 0;

   pcie_rx #(.ADDR_BITS(10)) dut (
      .clock     (clock),
      .reset     (reset),
      .rx_tdata  (rx_tdata),
      .rx_tvalid (rx_tvalid),
      .rx_tlast  (rx_tlast),
      .rx_tready (rx_tready),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_addr   (rd_addr),
      .rd_dw2    (rd_dw2),
      .cpl_valid (cpl_valid),
      .cpl_data  (cpl_data),
      .cpl_tag   (cpl_tag),
`ifdef PCIE_RX_CPL_STATUS_EN
      .cpl_error (cpl_error),
`endif
      .cpl_index (cpl_index)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Byte reversal of a DW, as the payload is delivered to the fabric
   function automatic logic [31:0] sw(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   // Distinct-byte payload DW number i
   function automatic logic [31:0] dw(input int i);
      return 32'h03020100 + 32'h04040404 * i;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic vld(input string tag, input logic w, input logic r, input logic c);
      chk({tag, "_wr_valid"}, wr_valid, w);
      chk({tag, "_rd_valid"}, rd_valid, r);
      chk({tag, "_cpl_valid"}, cpl_valid, c);
   endtask

   // One valid beat; on return the registered outputs for that beat are visible.
   task automatic send(input logic [63:0] d, input logic l);
      @(negedge clock);
      rx_tdata  = d;
      rx_tvalid = 1'b1;
      rx_tlast  = l;
      @(posedge clock);
      #1;
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
   endtask

   // One idle cycle with junk on the bus that must be ignored.
   task automatic gap(input logic [63:0] d);
      @(negedge clock);
      rx_tdata  = d;
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b1;
      @(posedge clock);
      #1;
      rx_tlast  = 1'b0;
   endtask

   initial begin
      reset     = 1'b0;
      rx_tdata  = 64'd0;
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("rst_tready", rx_tready, 1'b0);
      vld("rst", 1'b0, 1'b0, 1'b0);
      chk("rst_cpl_data", cpl_data, 64'd0);
      chk("rst_cpl_index", cpl_index, 6'd0);
      chk("rst_cpl_tag", cpl_tag, 8'd0);
      chk("rst_wr_addr", wr_addr, 10'd0);
      chk("rst_rd_dw2", rd_dw2, 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("tready_run", rx_tready, 1'b1);

      // MWr32 to byte address 0x10
      send({32'h0000000F, 32'h40000001}, 1'b0);
      vld("mwr_h0", 1'b0, 1'b0, 1'b0);
      send({32'h78563412, 32'h00000010}, 1'b1);
      vld("mwr_h1", 1'b1, 1'b0, 1'b0);
      chk("mwr_addr", wr_addr, 10'd4);
      chk("mwr_data", wr_data, 32'h12345678);
      gap(64'hFFFF_FFFF_FFFF_FFFF);
      vld("mwr_pulse", 1'b0, 1'b0, 1'b0);

      // Known type ending on beat 0: no output, next beat is a header again
      send({32'h00000000, 32'h40000001}, 1'b1);
      vld("short_tlp", 1'b0, 1'b0, 1'b0);

      // MRd32 at byte address 0x24
      send({32'h01002A0F, 32'h00000001}, 1'b0);
      vld("mrd_h0", 1'b0, 1'b0, 1'b0);
      send({32'h00000000, 32'h00000024}, 1'b1);
      vld("mrd_h1", 1'b0, 1'b1, 1'b0);
      chk("mrd_addr", rd_addr, 10'd9);
      chk("mrd_dw2", rd_dw2, 32'h01002A24);

      // MRd64 at byte address 0xC4
      send({32'hBEEF5500, 32'h20000001}, 1'b0);
      send({32'h000000C4, 32'h00000000}, 1'b1);
      vld("mrd64", 1'b0, 1'b1, 1'b0);
      chk("mrd64_addr", rd_addr, 10'h031);
      chk("mrd64_dw2", rd_dw2, 32'hBEEF5544);

      // MWr64 at byte address 0x8, payload on the third beat
      send({32'h0000000F, 32'h60000001}, 1'b0);
      send({32'h00000008, 32'h00000000}, 1'b0);
      vld("mwr64_h1", 1'b0, 1'b0, 1'b0);
      send({32'h00000000, 32'h04030201}, 1'b1);
      vld("mwr64_d", 1'b1, 1'b0, 1'b0);
      chk("mwr64_addr", wr_addr, 10'd2);
      chk("mwr64_data", wr_data, 32'h01020304);

      // CplD tag 0x13, 16 DW, byte count 512
      send({32'h00000200, 32'h4A000010}, 1'b0);
      send({dw(0), 32'h01001300}, 1'b0);
      vld("cpl1_hdr", 1'b0, 1'b0, 1'b0);
      chk("cpl1_tag", cpl_tag, 8'h13);
      for (int j = 0; j < 8; j++) begin
         send({dw(2*j+2), dw(2*j+1)}, j == 7);
         chk("cpl1_valid", cpl_valid, 1'b1);
         chk("cpl1_index", cpl_index, j[5:0]);
         chk("cpl1_data", cpl_data, {sw(dw(2*j+1)), sw(dw(2*j))});
         if (j == 0) chk("cpl1_first", cpl_data, 64'h0405060700010203);
      end
      gap(64'd0);
      vld("cpl1_end", 1'b0, 1'b0, 1'b0);

      // CplD tag 0x27, byte count 256: starts half way through the request
      send({32'h00000100, 32'h4A000002}, 1'b0);
      send({32'hAABBCCDD, 32'h01002700}, 1'b0);
      send({32'h00000000, 32'h11223344}, 1'b1);
      chk("cpl2_valid", cpl_valid, 1'b1);
      chk("cpl2_index", cpl_index, 6'd32);
      chk("cpl2_tag", cpl_tag, 8'h27);
      chk("cpl2_data", cpl_data, 64'h44332211_DDCCBBAA);

      // Unknown type 0x30: middle beats look like headers but must be dropped
      send({32'h00000000, 32'h30000001}, 1'b0);
      vld("unk_b0", 1'b0, 1'b0, 1'b0);
      send({32'h0000000F, 32'h40000001}, 1'b0);
      vld("unk_b1", 1'b0, 1'b0, 1'b0);
      send({32'h78563412, 32'h00000010}, 1'b1);
      vld("unk_b2", 1'b0, 1'b0, 1'b0);
      send({32'h0000000F, 32'h40000001}, 1'b0);
      send({32'hEFBEADDE, 32'h000003FC}, 1'b1);
      vld("unk_mwr", 1'b1, 1'b0, 1'b0);
      chk("unk_mwr_addr", wr_addr, 10'h0FF);
      chk("unk_mwr_data", wr_data, 32'hDEADBEEF);

      // CplD with tvalid gaps, then reset in the middle
      send({32'h00000200, 32'h4A000010}, 1'b0);
      send({32'hCAFEF00D, 32'h00000500}, 1'b0);
      gap(64'h5555_5555_5555_5555);
      gap(64'h6666_6666_6666_6666);
      vld("gap_idle", 1'b0, 1'b0, 1'b0);
      send({32'h22222222, 32'h11111111}, 1'b0);
      chk("gap_valid0", cpl_valid, 1'b1);
      chk("gap_index0", cpl_index, 6'd0);
      chk("gap_data0", cpl_data, 64'h11111111_0DF0FECA);
      gap(64'h7777_7777_7777_7777);
      vld("gap_mid", 1'b0, 1'b0, 1'b0);
      send({32'h44444444, 32'h33333333}, 1'b0);
      chk("gap_index1", cpl_index, 6'd1);
      chk("gap_data1", cpl_data, 64'h33333333_22222222);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("mid_rst_index", cpl_index, 6'd0);
      chk("mid_rst_tag", cpl_tag, 8'd0);
      chk("mid_rst_data", cpl_data, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      send({32'h12345600, 32'h00000001}, 1'b0);
      vld("post_rst_h0", 1'b0, 1'b0, 1'b0);
      send({32'h00000000, 32'h00000008}, 1'b1);
      vld("post_rst_h1", 1'b0, 1'b1, 1'b0);
      chk("post_rst_addr", rd_addr, 10'd2);
      chk("post_rst_dw2", rd_dw2, 32'h12345608);

      // Completion with status 3'b001, tag 0x44
      send({32'h00002200, 32'h4A000002}, 1'b0);
      send({32'hA1A2A3A4, 32'h01004400}, 1'b0);
      chk("stat_tag", cpl_tag, 8'h44);
`ifdef PCIE_RX_CPL_STATUS_EN
      chk("stat_error", cpl_error, 1'b1);
      send({32'h00000000, 32'hB1B2B3B4}, 1'b1);
      chk("stat_suppressed", cpl_valid, 1'b0);
      chk("stat_error_pulse", cpl_error, 1'b0);
`else
      send({32'h00000000, 32'hB1B2B3B4}, 1'b1);
      chk("stat_delivered", cpl_valid, 1'b1);
      chk("stat_data", cpl_data, 64'hB4B3B2B1_A4A3A2A1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
